// File: rtl/mips32_mc_pkg.sv
// mips32_mc_pkg : opcodes, funct codes, FSM state and ALU op encodings for the multi-cycle core
// rev 1.0
`default_nettype none

package mips32_mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_LUI = 3'd5
    } alu_op_t;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_JR, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
                    default: ok = 1'b0;
                endcase
            end
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI,
            OP_ORI, OP_LUI, OP_LW, OP_SW: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips32_regfile.sv
// mips32_regfile : 32x32 GPR file, two async read ports, one sync write port, r0 fixed at zero
// rev 1.0
`default_nettype none

module mips32_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b
);

    logic [31:0] regs [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs[raddr_b];

endmodule

`default_nettype wire

// File: rtl/mips32_multicycle.sv
// mips32_multicycle : FETCH/DECODE/EXEC/MEM/WB MIPS32 subset core on one shared req/ready memory port
// rev 1.0
`default_nettype none

module mips32_multicycle
    import mips32_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MEM_ADDR_W = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic [31:0]           pc,
    output logic                  retire,
    output logic                  halted
);

    state_t      state, next_state;
    alu_op_t     alu_op;
    logic [31:0] npc, ir, a, b, alu_out, mdr;
    logic [31:0] rf_a, rf_b, rf_wdata, pc_next, alu_b, alu_res, addr_src;
    logic [4:0]  rf_waddr;
    logic        rf_we, pc_load, xfer;

    wire  [5:0]  op       = ir[31:26];
    wire  [4:0]  rs       = ir[25:21];
    wire  [4:0]  rt       = ir[20:16];
    wire  [4:0]  rd       = ir[15:11];
    wire  [5:0]  funct    = ir[5:0];
    wire  [31:0] imm_sext = {{16{ir[15]}}, ir[15:0]};
    wire  [31:0] imm_ext  = (op == OP_ORI) ? {16'h0, ir[15:0]} : imm_sext;

    assign xfer = mem_req && mem_ready;

    mips32_regfile u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (rs),
        .raddr_b (rt),
        .rdata_a (rf_a),
        .rdata_b (rf_b)
    );

    always_comb begin
        alu_op = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            OP_ORI:  alu_op = ALU_OR;
            OP_LUI:  alu_op = ALU_LUI;
            default: alu_op = ALU_ADD;
        endcase
    end

    assign alu_b = (op == OP_RTYPE) ? b : imm_ext;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD: alu_res = a + alu_b;
            ALU_SUB: alu_res = a - alu_b;
            ALU_AND: alu_res = a & alu_b;
            ALU_OR:  alu_res = a | alu_b;
            ALU_SLT: alu_res = ($signed(a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            ALU_LUI: alu_res = {ir[15:0], 16'h0};
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= next_state;
    end

    // pc update and GPR write are both decided here so they always land on the same edge
    always_comb begin
        next_state = state;
        pc_load    = 1'b0;
        pc_next    = npc;
        rf_we      = 1'b0;
        rf_waddr   = rd;
        rf_wdata   = alu_out;
        case (state)
            S_FETCH:  if (xfer) next_state = S_DECODE;
            S_DECODE: next_state = is_legal(op, funct) ? S_EXEC : S_HALT;
            S_EXEC: begin
                case (op)
                    OP_LW, OP_SW: next_state = S_MEM;
                    OP_BEQ, OP_BNE: begin
                        next_state = S_FETCH;
                        pc_load    = 1'b1;
                        if ((a == b) == (op == OP_BEQ)) pc_next = npc + {imm_sext[29:0], 2'b00};
                    end
                    OP_J, OP_JAL: begin
                        next_state = S_FETCH;
                        pc_load    = 1'b1;
                        pc_next    = {npc[31:28], ir[25:0], 2'b00};
                        rf_we      = (op == OP_JAL);
                        rf_waddr   = 5'd31;
                        rf_wdata   = npc;
                    end
                    OP_RTYPE: begin
                        if (funct == FN_JR) begin
                            next_state = S_FETCH;
                            pc_load    = 1'b1;
                            pc_next    = a;
                        end else begin
                            next_state = S_WB;
                        end
                    end
                    default: next_state = S_WB;
                endcase
            end
            S_MEM: begin
                if (xfer) begin
                    if (op == OP_SW) begin
                        next_state = S_FETCH;
                        pc_load    = 1'b1;
                    end else begin
                        next_state = S_WB;
                    end
                end
            end
            S_WB: begin
                next_state = S_FETCH;
                pc_load    = 1'b1;
                rf_we      = 1'b1;
                rf_waddr   = (op == OP_RTYPE) ? rd : rt;
                rf_wdata   = (op == OP_LW) ? mdr : alu_out;
            end
            S_HALT:  next_state = S_HALT;
            default: next_state = S_FETCH;
        endcase
    end

    // mem_req is a flop so reset can drop it asynchronously even though state resets to FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            npc     <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            mem_req <= 1'b0;
            retire  <= 1'b0;
        end else begin
            mem_req <= (next_state == S_FETCH) || (next_state == S_MEM);
            retire  <= pc_load;
            if (pc_load) pc <= pc_next;
            case (state)
                S_FETCH: if (xfer) begin
                    ir  <= mem_rdata;
                    npc <= pc + 32'd4;
                end
                S_DECODE: begin
                    a <= rf_a;
                    b <= rf_b;
                end
                S_EXEC: alu_out <= alu_res;
                S_MEM:  if (xfer && (op != OP_SW)) mdr <= mem_rdata;
                default: ;
            endcase
        end
    end

    assign addr_src  = (state == S_MEM) ? alu_out : pc;
    assign mem_addr  = mem_req ? {addr_src[MEM_ADDR_W-1:2], 2'b00} : '0;
    assign mem_we    = mem_req && (state == S_MEM) && (op == OP_SW);
    assign mem_wdata = mem_we ? b : 32'd0;
    assign halted    = (state == S_HALT);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_src[31:MEM_ADDR_W], addr_src[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_mips32_multicycle.sv
// tb_mips32_multicycle : directed program run against a wait-stated memory model
// rev 1.0
`default_nettype none

module tb_mips32_multicycle;

    logic        clk;
    logic        rst_n;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [17:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata, pc;

    logic [31:0] mem [0:1023];
    logic [17:0] wait_addr;
    int          wait_n;
    int          wcnt;
    int          need;
    int          cyc;
    int          st_cnt;
    logic [17:0] st_addr;
    logic [31:0] st_data;

    int compared;
    int mismatched;
    int last_retire;

    mips32_multicycle #(.RESET_PC(32'h100), .MEM_ADDR_W(18)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .pc        (pc),
        .retire    (retire),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign need      = (mem_addr == wait_addr) ? wait_n : 0;
    assign mem_ready = mem_req && (wcnt >= need);
    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_req && !mem_ready) wcnt <= wcnt + 1;
        else                       wcnt <= 0;
        if (mem_req && mem_ready && mem_we) begin
            st_cnt  <= st_cnt + 1;
            st_addr <= mem_addr;
            st_data <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step_retire(input logic [31:0] exp_pc, input int exp_cpi, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!retire && n < 100);
        check({tag, "_retire"}, {31'd0, retire}, 32'd1);
        if (exp_cpi > 0) check({tag, "_cycles"}, cyc - last_retire, exp_cpi);
        check({tag, "_pc"}, pc, exp_pc);
        last_retire = cyc;
    endtask

    initial begin
        int          n;
        int          bad;
        logic [31:0] acc;

        compared   = 0;
        mismatched = 0;
        wait_addr  = 18'h8;
        wait_n     = 3;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[2]   = 32'hDEADBEEF;
        mem[64]  = 32'h20010005;  // addi r1,r0,5
        mem[65]  = 32'h2002FFFD;  // addi r2,r0,-3
        mem[66]  = 32'h00221820;  // add  r3,r1,r2
        mem[67]  = 32'h0041202A;  // slt  r4,r2,r1
        mem[68]  = 32'h8C050008;  // lw   r5,8(r0)
        mem[69]  = 32'h10210002;  // beq  r1,r1,+2
        mem[72]  = 32'h14210002;  // bne  r1,r1,+2
        mem[73]  = 32'h08000080;  // j    0x200
        mem[128] = 32'h0C000010;  // jal  0x40
        mem[16]  = 32'h03E00008;  // jr   r31
        mem[129] = 32'hAC05000C;  // sw   r5,12(r0)
        mem[130] = 32'h3C061234;  // lui  r6,0x1234
        mem[131] = 32'h34C6F0F0;  // ori  r6,r6,0xF0F0
        mem[132] = 32'h00223822;  // sub  r7,r1,r2
        mem[133] = 32'h00224025;  // or   r8,r1,r2
        mem[134] = 32'h20000007;  // addi r0,r0,7
        mem[135] = 32'hFC000000;  // illegal opcode 0x3F

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {28'd0, mem_req, mem_we, retire, halted}, 32'd0);
        check("rst_addr", {14'd0, mem_addr}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_pc", pc, 32'h100);
        acc = '0;
        for (int i = 0; i < 32; i++) acc = acc | dut.u_rf.regs[i];
        check("rst_gprs", acc, 32'd0);

        rst_n = 1'b1;
        n = 0;
        while (!mem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("first_req", {31'd0, mem_req}, 32'd1);
        check("first_addr", {14'd0, mem_addr}, 32'h100);
        check("first_retire", {31'd0, retire}, 32'd0);

        step_retire(32'h104, 0, "addi1");
        step_retire(32'h108, 4, "addi2");
        step_retire(32'h10C, 4, "add");
        step_retire(32'h110, 4, "slt");
        check("r1", dut.u_rf.regs[1], 32'd5);
        check("r2", dut.u_rf.regs[2], 32'hFFFFFFFD);
        check("r3", dut.u_rf.regs[3], 32'd2);
        check("r4", dut.u_rf.regs[4], 32'd1);

        n = 0;
        while (!(mem_req && mem_addr == 18'h8) && n < 20) begin
            @(negedge clk);
            n++;
        end
        bad = 0;
        n   = 0;
        while (mem_req && n < 20) begin
            if (mem_addr != 18'h8 || mem_we) bad++;
            n++;
            @(negedge clk);
        end
        check("lw_req_cycles", n, 32'd4);
        check("lw_addr_stable", bad, 32'd0);
        step_retire(32'h114, 8, "lw");
        check("r5", dut.u_rf.regs[5], 32'hDEADBEEF);

        step_retire(32'h120, 3, "beq");
        check("beq_fetch", {14'd0, mem_addr}, 32'h120);
        step_retire(32'h124, 3, "bne");
        check("bne_fetch", {14'd0, mem_addr}, 32'h124);
        step_retire(32'h200, 3, "j");
        step_retire(32'h040, 3, "jal");
        check("r31", dut.u_rf.regs[31], 32'h204);
        step_retire(32'h204, 3, "jr");
        step_retire(32'h208, 4, "sw");
        check("sw_count", st_cnt, 32'd1);
        check("sw_addr", {14'd0, st_addr}, 32'hC);
        check("sw_data", st_data, 32'hDEADBEEF);
        step_retire(32'h20C, 4, "lui");
        step_retire(32'h210, 4, "ori");
        check("r6", dut.u_rf.regs[6], 32'h1234F0F0);
        step_retire(32'h214, 4, "sub");
        check("r7", dut.u_rf.regs[7], 32'd8);
        step_retire(32'h218, 4, "or");
        check("r8", dut.u_rf.regs[8], 32'hFFFFFFFD);
        step_retire(32'h21C, 4, "addi_r0");
        check("r0", dut.u_rf.regs[0], 32'd0);

        n = 0;
        while (!halted && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("halted", {31'd0, halted}, 32'd1);
        check("halt_cycles", n, 32'd2);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_req || retire || !halted || pc != 32'h21C) bad++;
        end
        check("halt_quiet", bad, 32'd0);

        // second run: reset lands while a store is stalled waiting for mem_ready
        mem[64]   = 32'hAC000010;  // sw r0,16(r0)
        wait_addr = 18'h10;
        wait_n    = 1000;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!(mem_req && mem_we) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("sw_pending", {31'd0, mem_we}, 32'd1);
        check("sw_pending_addr", {14'd0, mem_addr}, 32'h10);
        repeat (2) @(negedge clk);
        check("sw_still_waiting", {31'd0, mem_req}, 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_req_drop", {30'd0, mem_req, mem_we}, 32'd0);
        @(negedge clk);
        check("midrst_pc", pc, 32'h100);
        check("midrst_nostore", st_cnt, 32'd1);
        rst_n = 1'b1;
        n = 0;
        while (!mem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("resume_addr", {14'd0, mem_addr}, 32'h100);
        check("resume_we", {31'd0, mem_we}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
